array_repack_seq: RTL and testbench
===================================

# array_repack_seq

Sequencer that accepts one packed multidimensional word, shape `[N_I-1:0][N_J-1:0][W-1:0]`, over a valid/ready handshake. It emits the word element by element (one W-bit element per transfer), each element tagged with its (i,j) index. It is the controller that drives element-by-element repacking between packed-bus producers and per-element consumers in the prsim/VPI cosim test environment, replacing hand-written generate loops at module boundaries.

## Interface
- `N_I`, default 2: outer dimension size; must be ≥1.
- `N_J`, default 3: inner dimension size; must be ≥1.
- `W`, default 4: element width in bits; must be ≥1.
- `IW`, `JW` (localparams): `max(1,$clog2(N_I))` and `max(1,$clog2(N_J))`.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  N_I*N_J*W  packed word.
- `out_valid`  out  1  element offered on `out_data`.
- `out_ready`  in  1  consumer accepts the element.
- `out_data`  out  W  current element.
- `out_i`  out  IW  outer index of the current element.
- `out_j`  out  JW  inner index of the current element.
- `out_last`  out  1  current element is (N_I-1, N_J-1).
- `busy`  out  1  a word is held and not yet fully emitted.
- `done`  out  1  one-cycle pulse after the last element transfers.

## Operation
- Element (i,j) is `in_data[(i*N_J+j)*W +: W]`, which matches SystemVerilog packed layout.
- The FSM has two states: IDLE and SEND.
- IDLE:
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - On `in_valid & in_ready`: capture `in_data` into the hold register, set i=0 and j=0, then go to SEND.
- SEND:
  - `in_ready`=0, `out_valid`=1, `busy`=1.
  - `out_data`, `out_i` and `out_j` reflect the held word at the current (i,j).
  - On `out_valid & out_ready`:
    - If j<N_J-1: j increments.
    - Otherwise j wraps to 0 and i increments.
    - If `out_last` was 1: go to IDLE and assert `done` for the following cycle.
- Order is i-major, j-minor: (0,0), (0,1) … (N_I-1, N_J-1).
- While `out_valid & !out_ready`, `out_data`, `out_i`, `out_j` and `out_last` hold stable.
- `done` is high in the first IDLE cycle. `in_ready` is also 1 in that cycle, so a new word can be accepted while `done` is high.
- `in_data` is ignored in SEND. The held word does not change until the next accept.
- If N_I=N_J=1, the first element already has `out_last`=1.

## Timing
- Reset values: `in_ready`=0 while `rst` is high, then 1 in the first cycle after reset. `out_valid`=0, `out_data`=0, `out_i`=0, `out_j`=0, `out_last`=0, `busy`=0, `done`=0. State is IDLE.
- Latency from accept to first `out_valid` is 1 cycle.
- With `out_ready` held at 1, throughput is N_I*N_J+1 cycles per word (6 transfers plus 1 IDLE cycle at the defaults).
- Reset mid-SEND aborts immediately: remaining elements are dropped, no `done` pulse, state returns to IDLE.
- `rst` takes priority over any handshake in the same cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid`/`out_ready` to any output.

## Configuration
- Macro: `ARRAY_REPACK_SEQ_PARITY_EN`.
- When defined:
  - Adds output `out_par` (1 bit) = XOR of `out_data`, registered alongside `out_data`. Reset value 0.
  - Adds output `par_err` (1 bit): a sticky flag, cleared only by `rst`. It sets when an accepted `in_data` has total XOR different from the optional input `in_par`. The `in_par` input is present only when the macro is defined.
- When undefined: `out_par`, `in_par` and `par_err` do not exist. All other behaviour is identical.

## Structure
- Package `array_repack_pkg`:
  - state enum `{ST_IDLE, ST_SEND}`;
  - default localparams `N_I_DEF`=2, `N_J_DEF`=3, `W_DEF`=4;
  - a function computing `max(1,$clog2(n))`.
- Sub-module `repack_index_ctr`: nested i/j counter with `clr`, `adv`, outputs `i`, `j`, `last`. It is parameterised by N_I and N_J and is reusable by future gather-side blocks.

## Test plan
- Reset, then `in_data`=24'hFEDCBA with `out_ready`=1 held → `out_data` is A, B, C, D, E, F over 6 consecutive cycles. (i,j) is (0,0) … (1,2). `out_last` is high only on F. `done` pulses one cycle later.
- Same word, `out_ready` toggled 1,0,0,1… → no element skipped or duplicated, and outputs stay stable during stalls.
- Back-to-back words 24'h123456 then 24'h654321, with `in_valid` held → the second word is accepted in the `done` cycle, and its first element (1) appears the next cycle.
- `rst` asserted after the 3rd element of 24'hFEDCBA → `out_valid`=0 the next cycle, no `done`; a following word 24'h000777 starts at element 7, index (0,0).
- `in_valid` asserted during SEND with different data → ignored; the emitted stream still matches the original word.
- With `ARRAY_REPACK_SEQ_PARITY_EN`, `in_data`=24'h000001 and `in_par`=0 → `par_err` sets and stays set until `rst`. `out_par`=1 on element 1 and 0 on the remaining elements.

Source files
------------

// File: rtl/array_repack_pkg.sv
// Shared types and sizing helpers for the packed-word repacking sequencer
// and its index counter.
package array_repack_pkg;

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  localparam int N_I_DEF = 2;
  localparam int N_J_DEF = 3;
  localparam int W_DEF   = 4;

  // Index width that stays legal for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/repack_index_ctr.sv
// Nested i-major/j-minor index counter; wraps to (0,0) after the last index.
module repack_index_ctr
  import array_repack_pkg::*;
#(
  parameter int N_I = N_I_DEF,
  parameter int N_J = N_J_DEF,
  localparam int IW = idx_w(N_I),
  localparam int JW = idx_w(N_J)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j,
  output logic          last
);

  localparam logic [IW-1:0] I_MAX = IW'(N_I - 1);
  localparam logic [JW-1:0] J_MAX = JW'(N_J - 1);

  logic i_end, j_end;

  assign i_end = (i == I_MAX);
  assign j_end = (j == J_MAX);
  assign last  = i_end && j_end;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      i <= '0;
      j <= '0;
    end else if (adv) begin
      if (j_end) begin
        j <= '0;
        i <= i_end ? '0 : i + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
    end
  end

endmodule

// File: rtl/array_repack_seq.sv
// Accepts one packed [N_I][N_J][W] word and emits it element by element with
// (i,j) tags. Optional parity: ARRAY_REPACK_SEQ_PARITY_EN.
module array_repack_seq
  import array_repack_pkg::*;
#(
  parameter int N_I = N_I_DEF,
  parameter int N_J = N_J_DEF,
  parameter int W   = W_DEF,
  localparam int IW = idx_w(N_I),
  localparam int JW = idx_w(N_J)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_I*N_J*W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic [IW-1:0]      out_i,
  output logic [JW-1:0]      out_j,
  output logic               out_last,
  output logic               busy,
`ifdef ARRAY_REPACK_SEQ_PARITY_EN
  input  logic               in_par,
  output logic               out_par,
  output logic               par_err,
`endif
  output logic               done
);

  state_e state_q, state_d;
  logic   up_q;
  logic   accept, adv;
  logic   ctr_last;
  logic   send;
  logic [IW-1:0] cur_i;
  logic [JW-1:0] cur_j;
  logic [N_I-1:0][N_J-1:0][W-1:0] hold;

  repack_index_ctr #(.N_I(N_I), .N_J(N_J)) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .adv  (adv),
    .i    (cur_i),
    .j    (cur_j),
    .last (ctr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      up_q    <= 1'b0;
      done    <= 1'b0;
      hold    <= '0;
    end else begin
      state_q <= state_d;
      up_q    <= 1'b1;
      done    <= send && out_ready && ctr_last;
      if (accept) hold <= in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          adv = 1'b1;
          if (ctr_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every output decodes registered state only; up_q keeps in_ready low
  // through the reset cycles.
  assign send      = (state_q == ST_SEND);
  assign in_ready  = (state_q == ST_IDLE) && up_q;
  assign out_valid = send;
  assign busy      = send;
  assign out_data  = send ? hold[cur_i][cur_j] : '0;
  assign out_i     = cur_i;
  assign out_j     = cur_j;
  assign out_last  = send && ctr_last;

`ifdef ARRAY_REPACK_SEQ_PARITY_EN
  assign out_par = ^out_data;

  always_ff @(posedge clk) begin
    if (rst)
      par_err <= 1'b0;
    else if (accept && ((^in_data) != in_par))
      par_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_array_repack_seq.sv
// Directed self-checking bench for array_repack_seq at default shape (2x3x4).
module tb_array_repack_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [0:0]  out_i;
  logic [1:0]  out_j;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef ARRAY_REPACK_SEQ_PARITY_EN
  logic        in_par;
  logic        out_par;
  logic        par_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_fe [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  logic [3:0] exp_12 [6] = '{4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] exp_65 [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
  logic [3:0] exp_77 [6] = '{4'h7, 4'h7, 4'h7, 4'h0, 4'h0, 4'h0};

  array_repack_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_i     (out_i),
    .out_j     (out_j),
    .out_last  (out_last),
    .busy      (busy),
`ifdef ARRAY_REPACK_SEQ_PARITY_EN
    .in_par    (in_par),
    .out_par   (out_par),
    .par_err   (par_err),
`endif
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef ARRAY_REPACK_SEQ_PARITY_EN
    in_par = 1'b0;
`endif
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    checks++; if ({out_i, out_j, out_last} !== 4'b0) begin errors++; $display("FAIL rst_idx got %b exp 0", {out_i, out_j, out_last}); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done got %b exp 00", {busy, done}); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_stream();
    in_data = 24'hFEDCBA; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got %b exp 1", k, out_valid); end
      checks++; if (out_data !== exp_fe[k]) begin errors++; $display("FAIL stream_data k=%0d got %h exp %h", k, out_data, exp_fe[k]); end
      checks++; if ({out_i, out_j} !== {1'(k / 3), 2'(k % 3)}) begin errors++; $display("FAIL stream_idx k=%0d got %b exp %b", k, {out_i, out_j}, {1'(k / 3), 2'(k % 3)}); end
      checks++; if (out_last !== (k == 5)) begin errors++; $display("FAIL stream_last k=%0d got %b exp %b", k, out_last, (k == 5)); end
      checks++; if ({busy, in_ready, done} !== 3'b100) begin errors++; $display("FAIL stream_flags k=%0d got %b exp 100", k, {busy, in_ready, done}); end
      step();
    end
    checks++; if ({done, out_valid, in_ready} !== 3'b101) begin errors++; $display("FAIL stream_done got %b exp 101", {done, out_valid, in_ready}); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stream_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_stall();
    int k = 0;
    int c = 0;
    logic rdy;
    in_data = 24'hFEDCBA; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    while (k < 6 && c < 40) begin
      rdy = (c % 3 == 0);
      out_ready = rdy;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c=%0d got %b exp 1", c, out_valid); end
      checks++; if (out_data !== exp_fe[k]) begin errors++; $display("FAIL stall_data c=%0d got %h exp %h", c, out_data, exp_fe[k]); end
      checks++; if ({out_i, out_j} !== {1'(k / 3), 2'(k % 3)}) begin errors++; $display("FAIL stall_idx c=%0d got %b exp %b", c, {out_i, out_j}, {1'(k / 3), 2'(k % 3)}); end
      checks++; if (out_last !== (k == 5)) begin errors++; $display("FAIL stall_last c=%0d got %b exp %b", c, out_last, (k == 5)); end
      step();
      if (rdy) k++;
      c++;
    end
    checks++; if (k != 6) begin errors++; $display("FAIL stall_timeout got %0d exp 6", k); end
    checks++; if ({done, out_valid} !== 2'b10) begin errors++; $display("FAIL stall_done got %b exp 10", {done, out_valid}); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    in_data = 24'h123456; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_data = 24'h654321;
    for (int k = 0; k < 6; k++) begin
      checks++; if (out_data !== exp_12[k]) begin errors++; $display("FAIL b2b_first k=%0d got %h exp %h", k, out_data, exp_12[k]); end
      step();
    end
    checks++; if ({done, in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_done_ready got %b exp 11", {done, in_ready}); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %b exp 1", out_valid); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (out_data !== exp_65[k]) begin errors++; $display("FAIL b2b_second k=%0d got %h exp %h", k, out_data, exp_65[k]); end
      step();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b exp 1", done); end
    step();
  endtask

  task automatic test_ignore();
    in_data = 24'hFEDCBA; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_data = 24'h123456;
    for (int k = 0; k < 6; k++) begin
      checks++; if (out_data !== exp_fe[k]) begin errors++; $display("FAIL ignore_data k=%0d got %h exp %h", k, out_data, exp_fe[k]); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ignore_ready k=%0d got %b exp 0", k, in_ready); end
      if (k == 5) in_valid = 1'b0;
      step();
    end
    checks++; if ({done, out_valid} !== 2'b10) begin errors++; $display("FAIL ignore_done got %b exp 10", {done, out_valid}); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ignore_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    in_data = 24'hFEDCBA; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_data !== exp_fe[k]) begin errors++; $display("FAIL rmid_pre k=%0d got %h exp %h", k, out_data, exp_fe[k]); end
      step();
    end
    rst = 1'b1;
    step();
    checks++; if ({out_valid, done, busy} !== 3'b000) begin errors++; $display("FAIL rmid_abort got %b exp 000", {out_valid, done, busy}); end
    rst = 1'b0;
    step();
    checks++; if ({done, in_ready, out_valid} !== 3'b010) begin errors++; $display("FAIL rmid_idle got %b exp 010", {done, in_ready, out_valid}); end
    in_data = 24'h000777; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if ({out_i, out_j} !== 3'b000) begin errors++; $display("FAIL rmid_idx got %b exp 000", {out_i, out_j}); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (out_data !== exp_77[k]) begin errors++; $display("FAIL rmid_data k=%0d got %h exp %h", k, out_data, exp_77[k]); end
      step();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_done got %b exp 1", done); end
    step();
  endtask

`ifdef ARRAY_REPACK_SEQ_PARITY_EN
  task automatic test_parity();
    in_data = 24'h000001; in_par = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_err k=%0d got %b exp 1", k, par_err); end
      checks++; if (out_par !== (k == 0)) begin errors++; $display("FAIL out_par k=%0d got %b exp %b", k, out_par, (k == 0)); end
      step();
    end
    step();
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_sticky got %b exp 1", par_err); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({par_err, out_par} !== 2'b00) begin errors++; $display("FAIL par_rst got %b exp 00", {par_err, out_par}); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
`ifdef ARRAY_REPACK_SEQ_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
